// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART sequencing driver.
package spart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_LOAD_LO  = 2'd0;
  localparam state_t S_LOAD_HI  = 2'd1;
  localparam state_t S_RUN      = 2'd2;
  localparam state_t S_CFG_WAIT = 2'd3;

  localparam logic [15:0] BAUD_00 = 16'h12C0;
  localparam logic [15:0] BAUD_01 = 16'h2580;
  localparam logic [15:0] BAUD_10 = 16'h4B00;
  localparam logic [15:0] BAUD_11 = 16'h9600;

  // Divisor word for a given DIP-switch baud select.
  function automatic logic [15:0] baud_word(input logic [1:0] cfg);
    case (cfg)
      2'b00:   baud_word = BAUD_00;
      2'b01:   baud_word = BAUD_01;
      2'b10:   baud_word = BAUD_10;
      default: baud_word = BAUD_11;
    endcase
  endfunction

endpackage

// File: rtl/spart_echo_fifo.sv
// Byte FIFO buffering received characters until the transmitter is free.
module spart_echo_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_din,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally; count moves by at most one per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spart_driver.sv
// SPART driver: loads the baud divisor, then echoes rx bytes back through tx.
module spart_driver
  import spart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             br_cfg,
  output logic [7:0]             baud_data,
  output logic                   sel_low,
  output logic                   sel_high,
  input  logic [7:0]             rx_data,
  input  logic                   rda,
  output logic                   rd_rx,
  output logic [7:0]             tx_data,
  output logic                   wrt_tx,
  input  logic                   tbr,
  output logic                   cfg_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  state_t      r_state;
  logic [1:0]  r_cfg_s1, r_cfg_s2, r_cfg_last;
  logic [7:0]  r_baud, r_tx_data;
  logic        r_sel_low, r_sel_high, r_busy, r_rd_rx, r_wrt_tx;

  logic        w_cfg_chg, w_push, w_pop, w_full, w_empty;
  logic [7:0]  w_head;
  logic [15:0] w_word;

  // The low byte uses the live synced select; the high byte uses the value
  // latched at the low-byte load so both halves always come from one word.
  assign w_word    = baud_word((r_state == S_LOAD_LO) ? r_cfg_s2 : r_cfg_last);
  assign w_cfg_chg = (r_cfg_s2 != r_cfg_last);

  // Handshakes only in RUN; the registered strobes block double reads/writes.
  assign w_push = (r_state == S_RUN) && rda && !r_rd_rx && !w_full;
  assign w_pop  = (r_state == S_RUN) && tbr && !r_wrt_tx && !w_empty;

  spart_echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (rx_data),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Two-flop synchronizer for the asynchronous DIP-switch select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_s1 <= br_cfg;
      r_cfg_s2 <= br_cfg;
    end else begin
      r_cfg_s1 <= br_cfg;
      r_cfg_s2 <= r_cfg_s1;
    end
  end

  // Configuration FSM plus registered rx/tx strobes and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD_LO;
      r_cfg_last <= br_cfg;
      r_baud     <= '0;
      r_sel_low  <= 1'b0;
      r_sel_high <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_rx    <= 1'b0;
      r_wrt_tx   <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_sel_low  <= 1'b0;
      r_sel_high <= 1'b0;
      r_rd_rx    <= w_push;
      r_wrt_tx   <= w_pop;
      if (w_pop) r_tx_data <= w_head;
      case (r_state)
        S_LOAD_LO: begin
          r_sel_low  <= 1'b1;
          r_baud     <= w_word[7:0];
          r_busy     <= 1'b1;
          r_cfg_last <= r_cfg_s2;
          r_state    <= S_LOAD_HI;
        end
        S_LOAD_HI: begin
          r_sel_high <= 1'b1;
          r_baud     <= w_word[15:8];
          r_busy     <= 1'b1;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_busy <= w_cfg_chg;
          if (w_cfg_chg) r_state <= S_CFG_WAIT;
        end
        S_CFG_WAIT: begin
          // Hold off the reload until tx is idle so no frame changes baud.
          r_busy <= 1'b1;
          if (tbr && !r_wrt_tx) r_state <= S_LOAD_LO;
        end
        default: r_state <= S_LOAD_LO;
      endcase
    end
  end

  assign baud_data = r_baud;
  assign sel_low   = r_sel_low;
  assign sel_high  = r_sel_high;
  assign cfg_busy  = r_busy;
  assign rd_rx     = r_rd_rx;
  assign wrt_tx    = r_wrt_tx;
  assign tx_data   = r_tx_data;

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Sequencing controller for the mini SPART datapath: baud_rate_gen, tx and rx.
- After reset, and after every br_cfg change, loads the 16-bit baud word into baud_rate_gen as a low byte, then a high byte.
- In run mode, pulls received bytes out of rx into an internal FIFO and echoes them in order through tx whenever the transmitter is free.
- Sits inside top_level between the DIP-switch inputs and the three SPART sub-blocks.

Parameters:
- DEPTH, 4, echo FIFO depth in bytes; must be a power of 2, 2..16.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- br_cfg  in  2  baud select from DIP switches; asynchronous to clk.
- baud_data  out  8  byte to baud_rate_gen data.
- sel_low  out  1  load baud_data into divisor low byte.
- sel_high  out  1  load baud_data into divisor high byte.
- rx_data  in  8  rx received byte (RxD_data); valid while rda=1.
- rda  in  1  rx receive-data-available.
- rd_rx  out  1  one-cycle acknowledge to rx.
- tx_data  out  8  byte to tx data.
- wrt_tx  out  1  one-cycle transmit strobe to tx en_tx.
- tbr  in  1  tx buffer ready (idle).
- cfg_busy  out  1  high during the baud reconfiguration sequence.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: all outputs 0; FIFO emptied; FSM = LOAD_LO; synchronizer and cfg_last are loaded with the raw br_cfg value.
- br_cfg sync: two-flop synchronizer. cfg_chg = sync value != cfg_last.
- Baud word table, indexed by the synced br_cfg:
  - 00 = 0x12C0
  - 01 = 0x2580
  - 10 = 0x4B00
  - 11 = 0x9600
- FSM states: LOAD_LO, LOAD_HI, RUN, CFG_WAIT. All outputs are registered.
  - LOAD_LO (one cycle): sel_low=1, baud_data=word[7:0], cfg_last<=synced cfg, cfg_busy=1. Next state: LOAD_HI.
  - LOAD_HI (one cycle): sel_high=1, baud_data=word[15:8], cfg_busy=1. Next state: RUN.
  - RUN: sel_low, sel_high, cfg_busy all 0; baud_data holds its last value. If cfg_chg, next state is CFG_WAIT.
  - CFG_WAIT: cfg_busy=1. Go to LOAD_LO when tbr=1 and wrt_tx=0. The divisor never changes mid-frame.
  - In LOAD_LO, LOAD_HI and CFG_WAIT: no new rd_rx or wrt_tx is issued. The FIFO contents are kept.
- RX side (RUN only):
  - Trigger: at an edge where rda=1, rd_rx=0 and FIFO not full.
  - Action: push rx_data at that edge; rd_rx=1 for the following cycle only.
  - The registered rd_rx blocks a double read while rx drops rda.
  - FIFO full: rda is left unacknowledged (no drop inside the driver) until space frees.
- TX side (RUN only):
  - Trigger: at an edge where tbr=1, wrt_tx=0 and fifo_count>0.
  - Action: pop the head into tx_data; wrt_tx=1 for the following cycle.
  - tx_data holds until the next pop. tx must drop tbr within one cycle of en_tx.
- Simultaneous push and pop on the same edge: both occur and fifo_count is unchanged.
- Empty FIFO plus rda: the pop condition uses the pre-edge count, so there is no bypass. Minimum echo latency is rda edge N → wrt_tx high in cycle N+2.
- Pointers: $clog2(DEPTH) bits, natural wrap. fifo_count is updated +1, -1 or 0; it never exceeds DEPTH and never underflows.
- Reset mid-operation: rd_rx and wrt_tx are cleared immediately. A partially sent frame is abandoned. The reload sequence restarts after rst is released.

Decomposition:
- spart_pkg holds:
  - state enum (LOAD_LO, LOAD_HI, RUN, CFG_WAIT);
  - the four baud word constants;
  - a function mapping br_cfg to the baud word.
- One sub-module, spart_echo_fifo: synchronous FIFO with push/pop/full/empty/count, parameter DEPTH. Instantiated once.
- Configuration FSM and the rx/tx handshake logic stay in spart_driver.

Test Plan:
- Release rst with br_cfg=01:
  - next cycle: sel_low=1, baud_data=0x80;
  - following cycle: sel_high=1, baud_data=0x25;
  - then cfg_busy=0.
- Repeat for br_cfg=00, 10, 11: expect low/high pairs C0/12, 00/4B, 00/96.
- RUN, tbr=1; pulse rda with rx_data=0x40 → exactly one rd_rx cycle, then wrt_tx high two cycles after the rda edge with tx_data=0x40; fifo_count returns to 0.
- Hold tbr=0 and deliver 5 bytes 0x11..0x15:
  - 4 rd_rx pulses; fifo_count=4; the 5th rda stays unacknowledged.
  - Raise tbr and model tx → 0x11..0x15 transmitted in order; the 5th byte is read once a slot frees.
- br_cfg 01→11 while tbr=0 and 2 bytes queued → cfg_busy=1 and no sel pulses or wrt_tx until tbr=1; then 0x00/0x96 loads; fifo_count still 2; echo resumes.
- fifo_count=1, rda=1 and tbr=1 on the same edge → rd_rx and wrt_tx both pulse; count stays 1.
- Assert rst mid-echo with 3 bytes queued → all outputs 0 asynchronously, fifo_count=0, and the full reload sequence follows release.
